// File: rtl/version_reporter.sv
// version_reporter: streams the build version/date as an ASCII line over a valid/ready byte interface.
package version_pkg;
  localparam logic [7:0]  C_VERSION_MAJOR  = 8'd0;
  localparam logic [7:0]  C_VERSION_MINOR  = 8'd0;
  localparam logic [7:0]  C_VERSION_PATCH  = 8'd0;
  localparam logic [7:0]  C_VERSION_BUILD  = 8'd57;
  localparam logic [15:0] C_VERSION_YEAR   = 16'h2025;
  localparam logic [7:0]  C_VERSION_MONTH  = 8'h11;
  localparam logic [7:0]  C_VERSION_DAY    = 8'h07;
  localparam logic [7:0]  C_VERSION_HOUR   = 8'h12;
  localparam logic [7:0]  C_VERSION_MINUTE = 8'h18;
  localparam logic [7:0]  C_VERSION_SECOND = 8'h15;
endpackage

module version_reporter #(
  parameter logic [7:0]  VERSION_MAJOR  = version_pkg::C_VERSION_MAJOR,
  parameter logic [7:0]  VERSION_MINOR  = version_pkg::C_VERSION_MINOR,
  parameter logic [7:0]  VERSION_PATCH  = version_pkg::C_VERSION_PATCH,
  parameter logic [7:0]  VERSION_BUILD  = version_pkg::C_VERSION_BUILD,
  parameter logic [15:0] VERSION_YEAR   = version_pkg::C_VERSION_YEAR,
  parameter logic [7:0]  VERSION_MONTH  = version_pkg::C_VERSION_MONTH,
  parameter logic [7:0]  VERSION_DAY    = version_pkg::C_VERSION_DAY,
  parameter logic [7:0]  VERSION_HOUR   = version_pkg::C_VERSION_HOUR,
  parameter logic [7:0]  VERSION_MINUTE = version_pkg::C_VERSION_MINUTE,
  parameter logic [7:0]  VERSION_SECOND = version_pkg::C_VERSION_SECOND
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_i,
  output logic       busy_o,
  output logic       done_o,
  output logic [7:0] tx_data_o,
  output logic       tx_valid_o,
  input  logic       tx_ready_i
);
  localparam int MAX_LEN = 38;

  function automatic int dec_digits(int v);
    return v >= 100 ? 3 : v >= 10 ? 2 : 1;
  endfunction

  function automatic logic [7:0] bcd_char(logic [3:0] n);
    return n < 4'd10 ? 8'h30 + {4'h0, n} : 8'h3F;
  endfunction

  // Whole line is rendered at elaboration; the datapath only walks a constant table.
  function automatic logic [MAX_LEN-1:0][7:0] build_line();
    logic [MAX_LEN-1:0][7:0] l;
    logic [31:0] bin;
    logic [55:0] bcd;
    logic [5:0] n;
    int v;
    l = '0;
    n = '0;
    bin = {VERSION_MAJOR, VERSION_MINOR, VERSION_PATCH, VERSION_BUILD};
    bcd = {VERSION_YEAR, VERSION_MONTH, VERSION_DAY, VERSION_HOUR, VERSION_MINUTE, VERSION_SECOND};
    for (int f = 0; f < 4; f++) begin
      l[n] = f == 0 ? "v" : f == 3 ? "+" : ".";
      n = n + 6'd1;
      v = int'(bin[31:24]);
      bin = bin << 8;
      if (v >= 100) begin
        l[n] = 8'(48 + v / 100);
        n = n + 6'd1;
      end
      if (v >= 10) begin
        l[n] = 8'(48 + (v / 10) % 10);
        n = n + 6'd1;
      end
      l[n] = 8'(48 + v % 10);
      n = n + 6'd1;
    end
    for (int k = 0; k < 14; k++) begin
      if (k % 2 == 0 && k != 2) begin
        l[n] = k == 0 || k == 8 ? " " : k < 8 ? "-" : ":";
        n = n + 6'd1;
      end
      l[n] = bcd_char(bcd[55:52]);
      bcd = bcd << 4;
      n = n + 6'd1;
    end
    l[n] = 8'h0D;
    l[n+6'd1] = 8'h0A;
    return l;
  endfunction

  localparam int LEN = 26 + dec_digits(int'(VERSION_MAJOR)) + dec_digits(int'(VERSION_MINOR))
                     + dec_digits(int'(VERSION_PATCH)) + dec_digits(int'(VERSION_BUILD));
  localparam logic [5:0] LAST = 6'(LEN - 1);
  localparam logic [MAX_LEN-1:0][7:0] LINE = build_line();

  typedef enum logic {IDLE, SEND} state_t;

  state_t     state, state_n;
  logic [5:0] idx, idx_n;
  logic [7:0] data_n;
  logic       done_n;
  logic       last;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= '0;
      tx_data_o <= '0;
      done_o    <= 1'b0;
    end else begin
      state     <= state_n;
      idx       <= idx_n;
      tx_data_o <= data_n;
      done_o    <= done_n;
    end
  end

  always_comb begin
    state_n = state;
    idx_n   = idx;
    data_n  = tx_data_o;
    done_n  = 1'b0;
    last    = idx == LAST;
    if (state == IDLE && req_i) begin
      state_n = SEND;
      idx_n   = '0;
      data_n  = LINE[0];
    end else if (state == SEND && tx_ready_i) begin
      state_n = last ? IDLE : SEND;
      done_n  = last;
      idx_n   = last ? 6'd0 : idx + 6'd1;
      data_n  = last ? 8'h00 : LINE[idx + 6'd1];
    end
  end

  assign busy_o     = state == SEND;
  assign tx_valid_o = state == SEND;
endmodule

// File: tb/tb_version_reporter.sv
// tb_version_reporter: randomized-handshake bench comparing three parameterizations against string models.
module tb_version_reporter;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req [3];
  logic       rdy [3];
  logic       busy [3];
  logic       done [3];
  logic       valid [3];
  logic [7:0] data [3];

  int    errors = 0;
  int    checks = 0;
  int    cyc = 0;
  int    pct [3] = '{100, 100, 100};
  int    hs [3] = '{0, 0, 0};
  int    lines [3] = '{0, 0, 0};
  int    done_cyc [3] = '{0, 0, 0};
  int    first_cyc [3] = '{0, 0, 0};
  string exp_line [3];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  version_reporter u_def (
    .clk(clk), .rst(rst), .req_i(req[0]), .busy_o(busy[0]), .done_o(done[0]),
    .tx_data_o(data[0]), .tx_valid_o(valid[0]), .tx_ready_i(rdy[0])
  );

  version_reporter #(
    .VERSION_MAJOR(8'd255), .VERSION_MINOR(8'd100), .VERSION_PATCH(8'd0), .VERSION_BUILD(8'd9)
  ) u_big (
    .clk(clk), .rst(rst), .req_i(req[1]), .busy_o(busy[1]), .done_o(done[1]),
    .tx_data_o(data[1]), .tx_valid_o(valid[1]), .tx_ready_i(rdy[1])
  );

  version_reporter #(
    .VERSION_MONTH(8'h1A), .VERSION_SECOND(8'hF3)
  ) u_bad (
    .clk(clk), .rst(rst), .req_i(req[2]), .busy_o(busy[2]), .done_o(done[2]),
    .tx_data_o(data[2]), .tx_valid_o(valid[2]), .tx_ready_i(rdy[2])
  );

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic string nib(logic [3:0] n);
    if (n < 4'd10) return $sformatf("%0d", n);
    return "?";
  endfunction

  function automatic string bcd(logic [15:0] v, int nd);
    string s = "";
    logic [15:0] t = v << (4 * (4 - nd));
    for (int i = 0; i < nd; i++) begin
      s = {s, nib(t[15:12])};
      t = t << 4;
    end
    return s;
  endfunction

  function automatic string model(int ma, int mi, int pa, int bu, logic [15:0] y,
                                  logic [7:0] mo, logic [7:0] dd, logic [7:0] hh,
                                  logic [7:0] mm, logic [7:0] ss);
    return $sformatf("v%0d.%0d.%0d+%0d %s-%s-%s %s:%s:%s\r\n", ma, mi, pa, bu,
                     bcd(y, 4), bcd(16'(mo), 2), bcd(16'(dd), 2), bcd(16'(hh), 2),
                     bcd(16'(mm), 2), bcd(16'(ss), 2));
  endfunction

  always begin
    @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) rdy[k] = $urandom_range(99) < pct[k];
  end

  // Per-instance scoreboard: inputs seen at the falling edge are what the next rising edge consumes.
  for (genvar g = 0; g < 3; g++) begin : mon
    bit         stall = 0;
    bit         dexp = 0;
    bit         rst_prev = 0;
    bit         vprev = 0;
    logic [7:0] sd = 8'h00;
    int         pos = 0;
    always @(negedge clk) begin
      if (rst_prev) begin
        check("rst_valid", 32'(valid[g]), 0);
        check("rst_busy", 32'(busy[g]), 0);
        check("rst_done", 32'(done[g]), 0);
        check("rst_data", 32'(data[g]), 0);
      end else begin
        check("done", 32'(done[g]), 32'(dexp));
        if (dexp) check("valid_after_last", 32'(valid[g]), 0);
        if (stall) begin
          check("hold_valid", 32'(valid[g]), 1);
          check("hold_data", 32'(data[g]), 32'(sd));
        end
      end
      check("busy_eq_valid", 32'(busy[g]), 32'(valid[g]));
      if (done[g] === 1'b1) begin
        lines[g]++;
        done_cyc[g] = cyc;
      end
      if (valid[g] === 1'b1 && !vprev) first_cyc[g] = cyc;
      dexp = 0;
      stall = 0;
      if (rst) pos = 0;
      else if (valid[g] === 1'b1 && rdy[g]) begin
        check("byte", 32'(data[g]), 32'(exp_line[g][pos]));
        hs[g]++;
        pos++;
        if (pos == exp_line[g].len()) begin
          pos = 0;
          dexp = 1;
        end
      end else if (valid[g] === 1'b1) begin
        stall = 1;
        sd = data[g];
      end
      rst_prev = rst;
      vprev = valid[g] === 1'b1;
    end
  end

  task automatic start(int k);
    req[k] = 1'b1;
    @(posedge clk);
    #1;
    req[k] = 1'b0;
    check("start_valid", 32'(valid[k]), 1);
    check("start_data", 32'(data[k]), 32'h76);
  endtask

  task automatic wait_lines(int k, int target, int budget);
    int n = 0;
    while (lines[k] < target && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("line_timeout", 32'(lines[k] >= target), 1);
  endtask

  initial begin
    int h, t, n;
    for (int k = 0; k < 3; k++) req[k] = 1'b0;
    exp_line[0] = "v0.0.0+57 2025-11-07 12:18:15\r\n";
    exp_line[1] = model(255, 100, 0, 9, 16'h2025, 8'h11, 8'h07, 8'h12, 8'h18, 8'h15);
    exp_line[2] = model(0, 0, 0, 57, 16'h2025, 8'h1A, 8'h07, 8'h12, 8'h18, 8'hF3);
    repeat (2) @(posedge clk);
    #1;
    check("reset_valid", 32'(valid[0]), 0);
    check("reset_data", 32'(data[0]), 0);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("idle_valid", 32'(valid[0]), 0);

    start(0);
    wait_lines(0, 1, 200);
    check("len_default", 32'(done_cyc[0] - first_cyc[0]), 31);

    pct[0] = 30;
    start(0);
    wait_lines(0, 2, 2000);
    pct[0] = 100;

    start(1);
    wait_lines(1, 1, 200);
    check("len_big", 32'(done_cyc[1] - first_cyc[1]), 34);
    pct[1] = 50;
    start(1);
    wait_lines(1, 2, 2000);

    pct[2] = 40;
    start(2);
    wait_lines(2, 1, 2000);
    pct[2] = 100;
    start(2);
    wait_lines(2, 2, 200);
    check("len_bad_bcd", 32'(done_cyc[2] - first_cyc[2]), 31);

    h = hs[0];
    pct[0] = 60;
    start(0);
    repeat (5) begin
      repeat ($urandom_range(4, 1)) @(posedge clk);
      #1;
      req[0] = 1'b1;
      @(posedge clk);
      #1;
      req[0] = 1'b0;
    end
    wait_lines(0, 3, 2000);
    repeat (5) @(posedge clk);
    #1;
    check("single_line", 32'(lines[0]), 3);
    check("single_hs", 32'(hs[0] - h), 31);
    check("single_idle", 32'(valid[0]), 0);

    pct[0] = 100;
    req[0] = 1'b1;
    wait_lines(0, 4, 200);
    t = done_cyc[0];
    wait_lines(0, 5, 200);
    check("b2b_period", 32'(done_cyc[0] - t), 32);
    req[0] = 1'b0;
    wait_lines(0, 6, 200);
    repeat (3) @(posedge clk);
    #1;
    check("held_release_idle", 32'(valid[0]), 0);

    h = hs[0];
    start(0);
    n = 0;
    while (hs[0] - h < 10 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("hs10_reached", 32'(hs[0] - h), 10);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("abort_valid", 32'(valid[0]), 0);
    check("abort_busy", 32'(busy[0]), 0);
    repeat (5) @(posedge clk);
    #1;
    check("abort_no_done", 32'(lines[0]), 6);
    start(0);
    wait_lines(0, 7, 200);
    check("restart_len", 32'(done_cyc[0] - first_cyc[0]), 31);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
